// File: rtl/apr_event_pkg.sv
// Shared types and constants for the APR event controller.
package apr_event_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      SERVICED = 2'd2
   } apr_state_t;

   localparam int PIA_W_DEF = 3;
   localparam int NCHAN_MAX = 16;

endpackage

// File: rtl/apr_event_chan.sv
// One APR event channel: edge/level detect, sticky flag, interrupt enable.
// Optional overrun tracking when APR_EVENT_OVERRUN_EN is defined.
module apr_event_chan #(
   parameter bit EDGE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic armed,
   input  logic evt,
   input  logic en,
   input  logic dis,
   input  logic set,
   input  logic clr,
   output logic flag,
`ifdef APR_EVENT_OVERRUN_EN
   output logic ovr,
`endif
   output logic int_en
);

   logic evt_q;
   logic hit;

   // Event condition; edge channels stay quiet on the first clock after reset
   always_comb begin
      hit = EDGE ? (evt & ~evt_q & armed) : evt;
   end

   // Sticky flag (event beats clear), enable (enable beats disable), edge history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_q  <= 1'b0;
         flag   <= 1'b0;
         int_en <= 1'b0;
      end else begin
         evt_q  <= evt;
         flag   <= hit | set | (flag & ~clr);
         int_en <= en | (int_en & ~dis);
      end
   end

`ifdef APR_EVENT_OVERRUN_EN
   // Overrun: a new event while the flag is still pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr <= 1'b0;
      end else begin
         ovr <= (hit & flag) | (ovr & ~clr);
      end
   end
`endif

endmodule

// File: rtl/apr_event_ctl.sv
// APR event controller: per-channel flags, priority encode and PI request FSM.
// Optional overrun outputs are built when APR_EVENT_OVERRUN_EN is defined.
module apr_event_ctl
   import apr_event_pkg::*;
#(
   parameter int               NCHAN     = 8,
   parameter logic [NCHAN-1:0] EDGE_MASK = '0,
   parameter int               PIA_W     = PIA_W_DEF
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic [NCHAN-1:0] evt_in,
   input  logic             sel_en,
   input  logic             sel_dis,
   input  logic             sel_set,
   input  logic             sel_clr,
   input  logic [NCHAN-1:0] ebus_data,
   input  logic             load_pia,
   input  logic [PIA_W-1:0] pia_in,
   input  logic             intr_ack,
   output logic [NCHAN-1:0] flags,
   output logic [NCHAN-1:0] int_en,
   output logic             intr_req,
   output logic [PIA_W-1:0] intr_pia,
   output logic [3:0]       intr_chan,
`ifdef APR_EVENT_OVERRUN_EN
   output logic [NCHAN-1:0] ovr,
`endif
   output logic             any_err
);

   apr_state_t             state;
   apr_state_t             state_nxt;
   logic                   armed;
   logic [3:0]             svc_chan;
   logic [NCHAN-1:0]       pend;
   logic [NCHAN_MAX-1:0]   pend_ext;
   logic                   any_pend;
   logic                   pia_on;

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      apr_event_chan #(.EDGE(EDGE_MASK[i])) u_chan (
         .clk    (clk),
         .rst    (RESET),
         .armed  (armed),
         .evt    (evt_in[i]),
         .en     (sel_en & ebus_data[i]),
         .dis    (sel_dis & ebus_data[i]),
         .set    (sel_set & ebus_data[i]),
         .clr    (sel_clr & ebus_data[i]),
         .flag   (flags[i]),
`ifdef APR_EVENT_OVERRUN_EN
         .ovr    (ovr[i]),
`endif
         .int_en (int_en[i])
      );
   end

   // Pending vector and lowest-numbered pending channel
   always_comb begin
      pend      = flags & int_en;
      pend_ext  = NCHAN_MAX'(pend);
      any_pend  = |pend;
      pia_on    = |intr_pia;
      intr_chan = 4'd0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         intr_chan = pend[i] ? 4'(i) : intr_chan;
      end
   end

   // Request FSM next state; SERVICED holds off new requests until its channel clears
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            state_nxt = (any_pend && pia_on) ? REQ : IDLE;
         end
         REQ: begin
            if (!any_pend || !pia_on) begin
               state_nxt = IDLE;
            end else if (intr_ack) begin
               state_nxt = SERVICED;
            end else begin
               state_nxt = REQ;
            end
         end
         SERVICED: begin
            state_nxt = pend_ext[svc_chan] ? SERVICED : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, registered request, PI assignment, serviced-channel latch and summary error
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         intr_req <= 1'b0;
         intr_pia <= '0;
         svc_chan <= 4'd0;
         any_err  <= 1'b0;
         armed    <= 1'b0;
      end else begin
         state    <= state_nxt;
         intr_req <= (state_nxt == REQ);
         any_err  <= |flags;
         armed    <= 1'b1;
         if (load_pia) begin
            intr_pia <= pia_in;
         end
         if ((state == REQ) && (state_nxt == SERVICED)) begin
            svc_chan <= intr_chan;
         end
      end
   end

endmodule

// File: tb/tb_apr_event_ctl.sv
// Randomized self-checking bench for apr_event_ctl against a cycle-level reference model.
// Overrun output is checked when APR_EVENT_OVERRUN_EN is defined.
module tb_apr_event_ctl;

   localparam int NCHAN = 8;
   localparam int PIA_W = 3;
   localparam logic [NCHAN-1:0] EDGE_MASK = 8'h80;

   logic             clk = 1'b0;
   logic             RESET;
   logic [NCHAN-1:0] evt_in;
   logic             sel_en, sel_dis, sel_set, sel_clr;
   logic [NCHAN-1:0] ebus_data;
   logic             load_pia;
   logic [PIA_W-1:0] pia_in;
   logic             intr_ack;
   logic [NCHAN-1:0] flags, int_en;
   logic             intr_req;
   logic [PIA_W-1:0] intr_pia;
   logic [3:0]       intr_chan;
   logic             any_err;
`ifdef APR_EVENT_OVERRUN_EN
   logic [NCHAN-1:0] ovr;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model: phase 0 = idle, 1 = requesting, 2 = serviced
   bit [7:0] m_flags, m_en, m_prev, m_ovr;
   bit       m_armed, m_anyerr;
   bit [2:0] m_pia;
   int       m_phase, m_svc;

   apr_event_ctl #(.NCHAN(NCHAN), .EDGE_MASK(EDGE_MASK), .PIA_W(PIA_W)) dut (
      .clk(clk), .RESET(RESET), .evt_in(evt_in),
      .sel_en(sel_en), .sel_dis(sel_dis), .sel_set(sel_set), .sel_clr(sel_clr),
      .ebus_data(ebus_data), .load_pia(load_pia), .pia_in(pia_in), .intr_ack(intr_ack),
      .flags(flags), .int_en(int_en), .intr_req(intr_req), .intr_pia(intr_pia),
      .intr_chan(intr_chan),
`ifdef APR_EVENT_OVERRUN_EN
      .ovr(ovr),
`endif
      .any_err(any_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int lowest(input bit [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_flags = '0; m_en = '0; m_prev = '0; m_ovr = '0;
      m_armed = 1'b0; m_anyerr = 1'b0; m_pia = '0; m_phase = 0; m_svc = 0;
   endtask

   task automatic quiet();
      evt_in = '0; sel_en = 0; sel_dis = 0; sel_set = 0; sel_clr = 0;
      ebus_data = '0; load_pia = 0; pia_in = '0; intr_ack = 0;
   endtask

   task automatic model_edge();
      bit [7:0] hit, setm, clrm, enm, dism, pend;
      setm = sel_set ? ebus_data : 8'h00;
      clrm = sel_clr ? ebus_data : 8'h00;
      enm  = sel_en  ? ebus_data : 8'h00;
      dism = sel_dis ? ebus_data : 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (EDGE_MASK[i]) hit[i] = evt_in[i] && !m_prev[i] && m_armed;
         else              hit[i] = evt_in[i];
      end
      pend = m_flags & m_en;
      if (m_phase == 0) begin
         if (pend != 0 && m_pia != 0) m_phase = 1;
      end else if (m_phase == 1) begin
         if (pend == 0 || m_pia == 0) m_phase = 0;
         else if (intr_ack) begin
            m_phase = 2;
            m_svc   = lowest(pend);
         end
      end else begin
         if (!pend[m_svc]) m_phase = 0;
      end
      m_ovr    = (hit & m_flags) | (m_ovr & ~clrm);
      m_anyerr = (m_flags != 0);
      m_flags  = hit | setm | (m_flags & ~clrm);
      m_en     = enm | (m_en & ~dism);
      if (load_pia) m_pia = pia_in;
      m_prev  = evt_in;
      m_armed = 1'b1;
   endtask

   task automatic compare_all();
      check_val("flags", flags, m_flags);
      check_val("int_en", int_en, m_en);
      check_val("intr_req", intr_req, (m_phase == 1));
      check_val("intr_chan", intr_chan, lowest(m_flags & m_en));
      check_val("intr_pia", intr_pia, m_pia);
      check_val("any_err", any_err, m_anyerr);
`ifdef APR_EVENT_OVERRUN_EN
      check_val("ovr", ovr, m_ovr);
`endif
   endtask

   // one clock: model follows the edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      quiet();
      RESET = 1'b1;
      model_reset();
      #12;
      check_val("rst_flags", flags, 8'h00);
      check_val("rst_int_en", int_en, 8'h00);
      check_val("rst_intr_req", intr_req, 1'b0);
      check_val("rst_intr_pia", intr_pia, 3'd0);
      check_val("rst_any_err", any_err, 1'b0);
      @(negedge clk);
      RESET = 1'b0;

      // pia=3, enable ch2, single-clock pulse on ch2
      load_pia = 1; pia_in = 3'd3; sel_en = 1; ebus_data = 8'h04;
      cycle();
      quiet();
      cycle();
      evt_in = 8'h04;
      cycle();
      evt_in = 8'h00;
      check_val("pulse_flags", flags, 8'h04);
      check_val("pulse_req_early", intr_req, 1'b0);
      cycle();
      check_val("pulse_req", intr_req, 1'b1);
      check_val("pulse_chan", intr_chan, 4'd2);

      // acknowledge, then clear the serviced channel
      intr_ack = 1;
      cycle();
      intr_ack = 0;
      check_val("ack_req_drop", intr_req, 1'b0);
      sel_clr = 1; ebus_data = 8'h04;
      cycle();
      quiet();
      cycle();
      cycle();
      check_val("svc_no_rereq", intr_req, 1'b0);

      // edge channel 7 held high for 10 clocks, cleared at the fifth
      evt_in = 8'h80;
      for (int k = 0; k < 10; k++) begin
         sel_clr = (k == 5); ebus_data = (k == 5) ? 8'h80 : 8'h00;
         cycle();
         if (k == 0) check_val("edge_set_once", flags[7], 1'b1);
      end
      check_val("edge_stays_clear", flags[7], 1'b0);
      quiet();
      cycle();

      // event beats clear; enable beats disable
      evt_in = 8'h02; sel_clr = 1; ebus_data = 8'h02;
      cycle();
      quiet();
      check_val("evt_wins_clr", flags[1], 1'b1);
      sel_en = 1; sel_dis = 1; ebus_data = 8'h01;
      cycle();
      quiet();
      check_val("en_wins_dis", int_en[0], 1'b1);

      // pending flags with pia=0, then assign pia=5
      sel_clr = 1; ebus_data = 8'hFF; load_pia = 1; pia_in = 3'd0;
      cycle();
      quiet();
      sel_en = 1; sel_set = 1; ebus_data = 8'h0A;
      cycle();
      quiet();
      cycle();
      cycle();
      check_val("pia0_no_req", intr_req, 1'b0);
      load_pia = 1; pia_in = 3'd5;
      cycle();
      quiet();
      cycle();
      check_val("pia5_req", intr_req, 1'b1);
      check_val("pia5_chan", intr_chan, 4'd1);
      check_val("pia5_pia", intr_pia, 3'd5);

      // asynchronous reset in the middle of a request
      #2;
      RESET = 1'b1;
      evt_in = 8'h81;
      #1;
      check_val("arst_req", intr_req, 1'b0);
      check_val("arst_flags", flags, 8'h00);
      check_val("arst_int_en", int_en, 8'h00);
      check_val("arst_pia", intr_pia, 3'd0);
      check_val("arst_chan", intr_chan, 4'd0);
      check_val("arst_any_err", any_err, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      RESET = 1'b0;
      cycle();
      check_val("post_rst_level_only", flags, 8'h01);
      evt_in = 8'h00;
      cycle();
      evt_in = 8'h01;
      cycle();
      evt_in = 8'h00;
      cycle();
      evt_in = 8'h01;
      cycle();
      evt_in = 8'h00;
`ifdef APR_EVENT_OVERRUN_EN
      check_val("ovr0", ovr[0], 1'b1);
`endif
      cycle();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         evt_in    = ($urandom_range(0, 2) == 0) ? 8'($urandom() & $urandom()) : 8'h00;
         ebus_data = 8'($urandom());
         sel_en    = ($urandom_range(0, 5) == 0);
         sel_dis   = ($urandom_range(0, 7) == 0);
         sel_set   = ($urandom_range(0, 9) == 0);
         sel_clr   = ($urandom_range(0, 3) == 0);
         load_pia  = ($urandom_range(0, 11) == 0);
         pia_in    = 3'($urandom_range(0, 7));
         intr_ack  = ($urandom_range(0, 2) == 0);
         cycle();
      end
      quiet();
      cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
